// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional signed operation is selected with the SIGNED_DIV_EN macro in sequential_divider.sv.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Width of the iteration counter that must hold WIDTH-1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Launch/result bundle of the sequential divider.
interface sequential_divider_if
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             start_in;
   logic [WIDTH-1:0] dividend_in;
   logic [WIDTH-1:0] divisor_in;
   logic             busy_out;
   logic             done_out;
   logic [WIDTH-1:0] quotient_out;
   logic [WIDTH-1:0] remainder_out;
   logic             div_by_zero_out;
   logic             overflow_out;

   modport master (
      output start_in, dividend_in, divisor_in,
      input  busy_out, done_out, quotient_out, remainder_out, div_by_zero_out, overflow_out
   );

   modport slave (
      input  start_in, dividend_in, divisor_in,
      output busy_out, done_out, quotient_out, remainder_out, div_by_zero_out, overflow_out
   );

endinterface

// File: rtl/divider_step.sv
// One restoring division iteration: shift a dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module divider_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             shift_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem_c,
   output logic             q_bit_c
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   // Trial subtraction at WIDTH+1 bits; the extra top bit is the borrow (negative result).
   always_comb begin
      shifted    = {rem, shift_bit};
      trial      = {1'b0, shifted} - {2'b00, divisor};
      q_bit_c    = ~trial[WIDTH+1];
      next_rem_c = q_bit_c ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating quotient, remainder
// carries the dividend sign, most-negative / -1 flags overflow_out).
// Results are formed on entry to DONE and published together with the done_out pulse
// on the following edge, so done_out appears WIDTH+1 edges after an accepted start.
module sequential_divider
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk_in,
   input  logic                rst_in,
   sequential_divider_if.slave bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] shq_q, shq_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             sn_q, sn_d;
   logic             sd_q, sd_d;
   logic [WIDTH-1:0] res_quo_q, res_quo_d;
   logic [WIDTH-1:0] res_rem_q, res_rem_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_out_q, dbz_out_d;
   logic             ovf_out_q, ovf_out_d;

   logic [WIDTH-1:0] step_rem_c;
   logic             step_qbit_c;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dvs_abs;
   logic             dvd_neg;
   logic             dvs_neg;
   logic             ovf_case;
   logic [WIDTH-1:0] quo_u;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem        (rem_q),
      .shift_bit  (shq_q[WIDTH-1]),
      .divisor    (div_q),
      .next_rem_c (step_rem_c),
      .q_bit_c    (step_qbit_c)
   );

   // Operand conditioning: magnitudes and signs for the launch path.
   always_comb begin
`ifdef SIGNED_DIV_EN
      dvd_neg  = bus.dividend_in[WIDTH-1];
      dvs_neg  = bus.divisor_in[WIDTH-1];
      dvd_abs  = dvd_neg ? WIDTH'(-bus.dividend_in) : bus.dividend_in;
      dvs_abs  = dvs_neg ? WIDTH'(-bus.divisor_in) : bus.divisor_in;
      ovf_case = (bus.dividend_in == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (bus.divisor_in == {WIDTH{1'b1}});
`else
      dvd_neg  = 1'b0;
      dvs_neg  = 1'b0;
      dvd_abs  = bus.dividend_in;
      dvs_abs  = bus.divisor_in;
      ovf_case = 1'b0;
`endif
   end

   // Next-state, datapath and output computation.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      shq_d       = shq_q;
      div_d       = div_q;
      sn_d        = sn_q;
      sd_d        = sd_q;
      res_quo_d   = res_quo_q;
      res_rem_d   = res_rem_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_out_d   = dbz_out_q;
      ovf_out_d   = ovf_out_q;
      done_d      = 1'b0;
      quo_u       = {shq_q[WIDTH-2:0], step_qbit_c};

      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) begin
               // Publish the results formed on entry to DONE.
               done_d      = 1'b1;
               quotient_d  = res_quo_q;
               remainder_d = res_rem_q;
               dbz_out_d   = dbz_q;
               ovf_out_d   = ovf_q;
               state_d     = IDLE;
            end
            if (bus.start_in) begin
               dbz_d = 1'b0;
               ovf_d = ovf_case;
               sn_d  = dvd_neg;
               sd_d  = dvs_neg;
               if (bus.divisor_in == '0) begin
                  state_d   = DONE;
                  res_quo_d = {WIDTH{1'b1}};
                  res_rem_d = bus.dividend_in;
                  dbz_d     = 1'b1;
                  ovf_d     = 1'b0;
               end else begin
                  state_d = CALC;
                  count_d = CW'(WIDTH - 1);
                  rem_d   = '0;
                  shq_d   = dvd_abs;
                  div_d   = dvs_abs;
               end
            end
         end
         CALC: begin
            rem_d = step_rem_c;
            shq_d = quo_u;
            if (count_q == '0) begin
               state_d   = DONE;
               res_quo_d = (sn_q ^ sd_q) ? WIDTH'(-quo_u) : quo_u;
               res_rem_d = sn_q ? WIDTH'(-step_rem_c) : step_rem_c;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         shq_q       <= '0;
         div_q       <= '0;
         sn_q        <= 1'b0;
         sd_q        <= 1'b0;
         res_quo_q   <= '0;
         res_rem_q   <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_out_q   <= 1'b0;
         ovf_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         shq_q       <= shq_d;
         div_q       <= div_d;
         sn_q        <= sn_d;
         sd_q        <= sd_d;
         res_quo_q   <= res_quo_d;
         res_rem_q   <= res_rem_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_out_q   <= dbz_out_d;
         ovf_out_q   <= ovf_out_d;
      end
   end

   // Drive the bus from registered outputs.
   always_comb begin
      bus.busy_out        = busy_q;
      bus.done_out        = done_q;
      bus.quotient_out    = quotient_q;
      bus.remainder_out   = remainder_q;
      bus.div_by_zero_out = dbz_out_q;
      bus.overflow_out    = ovf_out_q;
   end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=8), random and directed operations.
module tb_sequential_divider;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sequential_divider_if #(.WIDTH(W)) bus ();

   sequential_divider #(.WIDTH(W)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic ov);
      int sa;
      int sb;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         q  = {W{1'b1}};
         r  = a;
         dz = 1'b1;
      end else begin
`ifdef SIGNED_DIV_EN
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -(1 << (W - 1)) && sb == -1) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
         end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
         end
`else
         sa = int'(a);
         sb = int'(b);
         q  = W'(sa / sb);
         r  = W'(sa % sb);
`endif
      end
   endtask

   // Launch one operation, measure latency/busy, check results against the model.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic edz;
      logic eov;
      int lat;
      int busy_cnt;
      ref_div(a, b, eq, er, edz, eov);
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.dividend_in = a;
      bus.divisor_in  = b;
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      busy_cnt = bus.busy_out ? 1 : 0;
      lat = 0;
      while (!bus.done_out && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy_out) busy_cnt++;
      end
      check_eq({tag, " latency"}, lat, (b == 0) ? 1 : W + 1);
      check_eq({tag, " busy_cycles"}, busy_cnt, (b == 0) ? 0 : W);
      check_eq({tag, " quotient"}, bus.quotient_out, eq);
      check_eq({tag, " remainder"}, bus.remainder_out, er);
      check_eq({tag, " div_by_zero"}, bus.div_by_zero_out, edz);
      check_eq({tag, " overflow"}, bus.overflow_out, eov);
      @(posedge clk);
      #1;
      check_eq({tag, " done_single"}, bus.done_out, 1'b0);
      check_eq({tag, " result_hold"}, bus.quotient_out, eq);
   endtask

   initial begin
      int pulses;
      logic [W-1:0] cap_q;
      logic [W-1:0] cap_r;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst             = 1'b1;
      bus.start_in    = 1'b0;
      bus.dividend_in = '0;
      bus.divisor_in  = '0;
      #12;
      check_eq("reset busy", bus.busy_out, 1'b0);
      check_eq("reset done", bus.done_out, 1'b0);
      check_eq("reset quotient", bus.quotient_out, 0);
      check_eq("reset remainder", bus.remainder_out, 0);
      check_eq("reset flags", {bus.div_by_zero_out, bus.overflow_out}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed operations.
      run_op(8'd100, 8'd7, "d100_7");
      run_op(8'd55, 8'd0, "d55_0");
      run_op(8'd9, 8'd3, "d9_3");
      run_op(8'd255, 8'd1, "d255_1");
      run_op(8'd3, 8'd200, "d3_200");
      run_op(8'd255, 8'd255, "d255_255");
      run_op(8'h80, 8'hFF, "dmin_m1");
      run_op(8'hF9, 8'h02, "dm7_2");
      run_op(8'h07, 8'hFE, "d7_m2");
`ifdef SIGNED_DIV_EN
      run_op(8'hF9, 8'h02, "s_m7_2");
      check_eq("s_m7_2 const_q", bus.quotient_out, 8'hFD);
      check_eq("s_m7_2 const_r", bus.remainder_out, 8'hFF);
      run_op(8'h80, 8'hFF, "s_min_m1");
      check_eq("s_min_m1 const_ovf", bus.overflow_out, 1'b1);
`else
      run_op(8'd100, 8'd7, "u100_7");
      check_eq("u100_7 const_q", bus.quotient_out, 8'd14);
      check_eq("u100_7 const_r", bus.remainder_out, 8'd2);
`endif

      // Second start during CALC is ignored.
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.dividend_in = 8'd100;
      bus.divisor_in  = 8'd7;
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.dividend_in = 8'd50;
      bus.divisor_in  = 8'd5;
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      pulses = 0;
      cap_q  = '0;
      cap_r  = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_out) begin
            pulses++;
            cap_q = bus.quotient_out;
            cap_r = bus.remainder_out;
         end
      end
      check_eq("ignore done_pulses", pulses, 1);
      check_eq("ignore quotient", cap_q, 8'd14);
      check_eq("ignore remainder", cap_r, 8'd2);

      // Reset in the middle of CALC aborts the operation.
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.dividend_in = 8'd100;
      bus.divisor_in  = 8'd7;
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("abort busy", bus.busy_out, 1'b0);
      check_eq("abort done", bus.done_out, 1'b0);
      check_eq("abort quotient", bus.quotient_out, 0);
      check_eq("abort remainder", bus.remainder_out, 0);
      check_eq("abort flags", {bus.div_by_zero_out, bus.overflow_out}, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_out) pulses++;
      end
      check_eq("abort no_done", pulses, 0);
      run_op(8'd20, 8'd6, "after_abort");
      check_eq("after_abort const_q", bus.quotient_out, 8'd3);
      check_eq("after_abort const_r", bus.remainder_out, 8'd2);

      // Random operations, occasional zero divisor.
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
         run_op(ra, rb, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Multi-cycle restoring integer divider, the inverse datapath to the combinational multiplicator. It computes quotient and remainder of dividend_in / divisor_in, producing one quotient bit per clock. Operands are launched with a start/done handshake. The block sits beside the multiplicators as the arithmetic unit's divide path.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (legal values 2 to 32).

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_in  input  1  reset, asynchronous, active-high
start_in  input  1  launch request; sampled only when the block is not busy
dividend_in  input  WIDTH  dividend; latched on the accepting edge
divisor_in  input  WIDTH  divisor; latched on the accepting edge
busy_out  output  1  high while a division is in progress
done_out  output  1  one-cycle pulse; results valid
quotient_out  output  WIDTH  quotient; held until the next accepted start
remainder_out  output  WIDTH  remainder; held until the next accepted start
div_by_zero_out  output  1  latched divisor was zero; held with the results
overflow_out  output  1  signed overflow flag (see Optional Feature); held with the results

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE. All outputs and internal registers are 0.
- States:
  - IDLE: waits for start_in.
  - CALC: runs WIDTH iterations.
  - DONE: done_out=1 for exactly one cycle, then returns to IDLE.
- Accepting a start:
  - start_in=1 in IDLE or DONE latches both operands and clears the flags.
  - divisor!=0: go to CALC with iteration counter=WIDTH-1, partial remainder=0, shift register=dividend.
  - divisor==0: go directly to DONE. Results: quotient_out=all ones, remainder_out=dividend, div_by_zero_out=1.
- CALC iteration, one per cycle:
  - Shift {rem, q} left by 1.
  - trial = rem - divisor, computed at WIDTH+1 bits.
  - trial non-negative: rem=trial and q[0]=1. Otherwise restore rem and set q[0]=0.
  - When counter reaches 0, go to DONE and load quotient_out/remainder_out.
- Latency: start accepted at edge k gives done_out high in the cycle after edge k+WIDTH+1. Divide-by-zero gives done_out after edge k+1.
- busy_out=1 exactly while the state is CALC.
- start_in during CALC is ignored. The running operation is unaffected and no queueing takes place.
- start_in during DONE is accepted. done_out still pulses that cycle, and busy_out rises next cycle.
- Results and flags stay stable from done_out until the next accepted start. They are not cleared on the return to IDLE.
- Reset mid-CALC aborts the operation immediately. Outputs go to 0 and no done_out is produced.
- Unsigned mode: quotient = floor(dividend/divisor), remainder = dividend mod divisor. overflow_out is always 0.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement. Absolute values are divided and the signs fixed in DONE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient=most-negative, remainder=0, overflow_out=1.
  - Divide-by-zero gives quotient=all ones, remainder=dividend.
  - Latency is unchanged; sign correction is registered on the DONE transition.
- Not defined: pure unsigned operation, and overflow_out is tied to 0.

Decomposition:
- Package divider_pkg:
  - div_state_t enum {IDLE, CALC, DONE}.
  - DEFAULT_WIDTH=8.
  - Count-width helper function $clog2(WIDTH).
- Sub-module divider_step: combinational single restoring iteration.
  - Inputs: rem, shifted-in dividend bit, divisor.
  - Outputs: next rem, quotient bit.
- The top module holds the FSM, counter, operand latches and sign handling.

Test Plan:
- WIDTH=8, 100/7: quotient_out=14, remainder_out=2, done_out high exactly 9 edges after start; busy_out high for 8 cycles.
- 55/0: done_out after 1 edge, quotient_out=0xFF, remainder_out=55, div_by_zero_out=1. A following 9/3 gives 3 rem 0 with div_by_zero_out=0.
- Boundaries: 255/1 gives 255 rem 0; 3/200 gives 0 rem 3; 255/255 gives 1 rem 0.
- 100/7 started, then start_in=1 with 50/5 at cycle 3 of CALC: the second start is ignored, results are 14 rem 2, and done_out pulses once.
- Start 100/7, assert rst_in at CALC cycle 4: all outputs 0 immediately and no done_out. Then 20/6 gives 3 rem 2 with normal latency.
- SIGNED_DIV_EN: -7/2 gives 0xFD (-3) rem 0xFF (-1); 7/-2 gives -3 rem 1; -128/-1 gives 0x80 rem 0 with overflow_out=1.
